// File: rtl/testsig_pkg.sv
// Shared definitions for the test-signal generator.
//   - output mode encoding (matches the two mode LEDs)
//   - LFSR reload seed, feedback tap positions and next-state helper
//   - PWM phase field width
package testsig_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_PHASE  = 2'd1,
        MODE_PWM    = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          LFSR_TAP_A = 0;
    localparam int          LFSR_TAP_B = 2;
    localparam int          LFSR_TAP_C = 3;
    localparam int          LFSR_TAP_D = 5;

    localparam int          PWM_W      = 8;

    // Right-shifting Fibonacci LFSR: feedback enters at bit 15.
    function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
        logic fb;
        fb = cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D];
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/testsiggen_if.sv
// Board-side signal bundle of the test-signal generator.
//   iBtnMode, iBtnFreq : active-low push buttons (asynchronous to the clock)
//   oLed1, oLed2       : current mode, bit 0 and bit 1
//   oTestSig           : pChannels test outputs
//   oSync              : one-cycle scope trigger per tick
// The generator uses the slave modport; the board/bench uses master.
interface testsiggen_if #(
    parameter int pChannels = 4
);
    logic                 iBtnMode;
    logic                 iBtnFreq;
    logic                 oLed1;
    logic                 oLed2;
    logic [pChannels-1:0] oTestSig;
    logic                 oSync;

    modport master (
        output iBtnMode, iBtnFreq,
        input  oLed1, oLed2, oTestSig, oSync
    );

    modport slave (
        input  iBtnMode, iBtnFreq,
        output oLed1, oLed2, oTestSig, oSync
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debouncer and press pulse.
//   iClk, iRstN : clock and synchronous active-low reset
//   iBtnN       : raw active-low button level
//   oPress      : one-cycle pulse when the debounced level goes released->pressed
// The debounced level follows the synchronized level only after the two
// have disagreed for 2^pDebounceBits consecutive cycles; any agreeing
// sample restarts the count.
module btn_debounce #(
    parameter int pDebounceBits = 16
) (
    input  logic iClk,
    input  logic iRstN,
    input  logic iBtnN,
    output logic oPress
);

    localparam logic [pDebounceBits-1:0] cDbOne = pDebounceBits'(1);

    logic                     syncA;
    logic                     syncB;
    logic                     stable;
    logic [pDebounceBits-1:0] dbCnt;
    logic                     differs;
    logic                     qualified;

    assign differs   = (syncB != stable);
    // The counter saturating at all-ones means this is the 2^N-th differing sample.
    assign qualified = differs && (dbCnt == '1);

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            syncA  <= 1'b1;
            syncB  <= 1'b1;
            stable <= 1'b1;
            dbCnt  <= '0;
            oPress <= 1'b0;
        end else begin
            syncA  <= iBtnN;
            syncB  <= syncA;
            oPress <= qualified && !syncB;
            if (qualified) begin
                stable <= syncB;
                dbCnt  <= '0;
            end else if (differs) begin
                dbCnt  <= dbCnt + cDbOne;
            end else begin
                dbCnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/testsiggen.sv
// Multi-channel scope test-signal generator.
//   iClk, iRstN : sole clock, synchronous active-low reset
//   bus         : testsiggen_if.slave (buttons in; LEDs, test signals, sync out)
// A free-running counter provides the time base. The frequency button picks
// the tap bit (tap = pCntSize-1-freqSel); a tick fires whenever the counter
// bits below the tap are all ones. The mode button selects SQUARE (counter
// bits), PHASE (Johnson ring stepped per tick), PWM (phase compare) or
// LFSR (pseudo-random, stepped per tick). Johnson and LFSR always run and
// restart whenever the mode or frequency selection changes.
module testsiggen
    import testsig_pkg::*;
#(
    parameter int pChannels     = 4,
    parameter int pCntSize      = 16,
    parameter int pDebounceBits = 16
) (
    input  logic iClk,
    input  logic iRstN,
    testsiggen_if.slave bus
);

    generate
        if (pChannels < 1 || pChannels > 8 || pCntSize < 12 || pCntSize > 32 ||
            pCntSize < pChannels + 11 || pDebounceBits < 1) begin : gBadParams
            $error("testsiggen: illegal parameters pChannels=%0d pCntSize=%0d pDebounceBits=%0d",
                   pChannels, pCntSize, pDebounceBits);
        end
    endgenerate

    localparam logic [pCntSize-1:0] cCntOne = pCntSize'(1);

    logic                 modePress;
    logic                 freqPress;
    logic                 selChange;

    mode_e                mode;
    logic [1:0]           freqSel;
    logic [pCntSize-1:0]  cnt;
    logic [pChannels-1:0] johnson;
    logic [15:0]          lfsr;

    int                   tap;
    logic [pCntSize-1:0]  tapMask;
    logic                 tick;
    logic [pChannels-1:0] sqWin;
    logic [PWM_W-1:0]     phase;
    logic [pChannels-1:0] sqBits;
    logic [pChannels-1:0] pwmBits;
    logic                 johnsonIn;
    logic [pChannels-1:0] johnsonNext;
    logic [pChannels-1:0] testSigNext;

    logic [pChannels-1:0] testSigP1;
    logic                 tickP1;

    btn_debounce #(.pDebounceBits(pDebounceBits)) uBtnMode (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iBtnN  (bus.iBtnMode),
        .oPress (modePress)
    );

    btn_debounce #(.pDebounceBits(pDebounceBits)) uBtnFreq (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iBtnN  (bus.iBtnFreq),
        .oPress (freqPress)
    );

    assign selChange = modePress | freqPress;

    // Stage p0: tap decode, tick and per-mode channel candidates from current state
    always_comb begin
        tap       = pCntSize - 1 - int'(freqSel);
        tapMask   = (cCntOne << tap) - cCntOne;
        // Window whose MSB is cnt[tap]; channel k reads cnt[tap-k].
        sqWin     = pChannels'(cnt >> (tap - (pChannels - 1)));
        phase     = PWM_W'(cnt >> (tap - (PWM_W - 1)));
        johnsonIn = ~johnson[pChannels-1];
        johnsonNext = (johnson << 1) | pChannels'(johnsonIn);
    end

    assign tick = ((cnt & tapMask) == tapMask);

    genvar k;
    generate
        for (k = 0; k < pChannels; k++) begin : gChan
            localparam logic [PWM_W:0] cThr = (PWM_W + 1)'((k + 1) * (256 / (pChannels + 1)));
            assign sqBits[k]  = sqWin[pChannels-1-k];
            assign pwmBits[k] = ({1'b0, phase} < cThr);
        end
    endgenerate

    always_comb begin
        testSigNext = sqBits;
        case (mode)
            MODE_SQUARE: testSigNext = sqBits;
            MODE_PHASE:  testSigNext = johnson;
            MODE_PWM:    testSigNext = pwmBits;
            MODE_LFSR:   testSigNext = lfsr[pChannels-1:0];
            default:     testSigNext = sqBits;
        endcase
    end

    // Stage p1: state update and registered outputs
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            cnt       <= '0;
            mode      <= MODE_SQUARE;
            freqSel   <= 2'd0;
            johnson   <= '0;
            lfsr      <= LFSR_SEED;
            testSigP1 <= '0;
            tickP1    <= 1'b0;
        end else begin
            cnt <= cnt + cCntOne;
            if (modePress) begin
                mode <= mode_e'(mode + 2'd1);
            end
            if (freqPress) begin
                freqSel <= freqSel + 2'd1;
            end
            // A selection change restarts both generators so every mode starts from a known pattern.
            if (selChange) begin
                johnson <= '0;
                lfsr    <= LFSR_SEED;
            end else if (tick) begin
                johnson <= johnsonNext;
                lfsr    <= lfsrNext(lfsr);
            end
            testSigP1 <= testSigNext;
            tickP1    <= tick;
        end
    end

    assign bus.oTestSig = testSigP1;
    assign bus.oSync    = tickP1;
    assign bus.oLed1    = mode[0];
    assign bus.oLed2    = mode[1];

endmodule

// File: tb/tb_testsiggen.sv
module tb_testsiggen;

    logic iClk = 1'b0;
    logic iRstN;
    int   errors = 0;
    int   checks = 0;

    always #5 iClk = ~iClk;

    testsiggen_if #(.pChannels(4)) bus ();

    testsiggen #(
        .pChannels     (4),
        .pCntSize      (12),
        .pDebounceBits (3)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Returns the number of steps until oSync is seen high, or -1 on timeout.
    task automatic waitSync(output int n);
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            step();
            if (bus.oSync) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pressBtns(input logic m, input logic f, input int lowCycles);
        if (m) bus.iBtnMode = 1'b0;
        if (f) bus.iBtnFreq = 1'b0;
        stepN(lowCycles);
        bus.iBtnMode = 1'b1;
        bus.iBtnFreq = 1'b1;
        stepN(20);
    endtask

    task automatic test_reset();
        iRstN = 1'b0;
        bus.iBtnMode = 1'b1;
        bus.iBtnFreq = 1'b1;
        stepN(4);
        checks++;
        if (bus.oTestSig !== 4'b0000) begin
            errors++; $display("FAIL reset_testsig got=%b want=0000", bus.oTestSig);
        end
        checks++;
        if (bus.oSync !== 1'b0) begin
            errors++; $display("FAIL reset_sync got=%b want=0", bus.oSync);
        end
        checks++;
        if (bus.oLed1 !== 1'b0) begin
            errors++; $display("FAIL reset_led1 got=%b want=0", bus.oLed1);
        end
        checks++;
        if (bus.oLed2 !== 1'b0) begin
            errors++; $display("FAIL reset_led2 got=%b want=0", bus.oLed2);
        end
    endtask

    task automatic test_square();
        int r0a = -1, r0b = -1, r1a = -1, r1b = -1, sa = -1, sb = -1, wide = 0;
        logic p0 = 1'b0, p1 = 1'b0, ps = 1'b0;
        iRstN = 1'b1;
        for (int c = 1; c <= 8200; c++) begin
            step();
            if (!p0 && bus.oTestSig[0]) begin
                if (r0a < 0) r0a = c; else if (r0b < 0) r0b = c;
            end
            if (!p1 && bus.oTestSig[1]) begin
                if (r1a < 0) r1a = c; else if (r1b < 0) r1b = c;
            end
            if (bus.oSync) begin
                if (ps) wide++;
                if (sa < 0) sa = c; else if (sb < 0) sb = c;
            end
            p0 = bus.oTestSig[0];
            p1 = bus.oTestSig[1];
            ps = bus.oSync;
        end
        checks++;
        if (r0a !== 2049) begin
            errors++; $display("FAIL sq_ch0_first_rise got=%0d want=2049", r0a);
        end
        checks++;
        if (r0b - r0a !== 4096) begin
            errors++; $display("FAIL sq_ch0_period got=%0d want=4096", r0b - r0a);
        end
        checks++;
        if (r1a !== 1025) begin
            errors++; $display("FAIL sq_ch1_first_rise got=%0d want=1025", r1a);
        end
        checks++;
        if (r1b - r1a !== 2048) begin
            errors++; $display("FAIL sq_ch1_period got=%0d want=2048", r1b - r1a);
        end
        checks++;
        if (sa !== 2048) begin
            errors++; $display("FAIL sync_first got=%0d want=2048", sa);
        end
        checks++;
        if (sb - sa !== 2048) begin
            errors++; $display("FAIL sync_period got=%0d want=2048", sb - sa);
        end
        checks++;
        if (wide !== 0) begin
            errors++; $display("FAIL sync_width got=%0d extra high cycles want=0", wide);
        end
    endtask

    task automatic test_debounce();
        int n;
        waitSync(n);
        pressBtns(1'b1, 1'b0, 5);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b00) begin
            errors++; $display("FAIL debounce_short got=%b want=00", {bus.oLed2, bus.oLed1});
        end
        pressBtns(1'b1, 1'b0, 12);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b01) begin
            errors++; $display("FAIL debounce_long got=%b want=01", {bus.oLed2, bus.oLed1});
        end
    endtask

    task automatic test_phase();
        logic [3:0] expSeq [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
        int n;
        checks++;
        if (bus.oTestSig !== 4'b0000) begin
            errors++; $display("FAIL phase_start got=%b want=0000", bus.oTestSig);
        end
        for (int i = 0; i < 6; i++) begin
            waitSync(n);
            checks++;
            if (i == 0 && n < 0) begin
                errors++; $display("FAIL phase_tick_timeout got=%0d want>0", n);
            end else if (i > 0 && n + 1 !== 2048) begin
                errors++; $display("FAIL phase_step_interval got=%0d want=2048", n + 1);
            end
            step();
            checks++;
            if (bus.oTestSig !== expSeq[i]) begin
                errors++; $display("FAIL phase_step%0d got=%b want=%b", i, bus.oTestSig, expSeq[i]);
            end
        end
    endtask

    task automatic test_pwm();
        int hi [4] = '{0, 0, 0, 0};
        int expHi [4] = '{816, 1632, 2448, 3264};
        pressBtns(1'b1, 1'b0, 12);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b10) begin
            errors++; $display("FAIL pwm_leds got=%b want=10", {bus.oLed2, bus.oLed1});
        end
        for (int c = 0; c < 4096; c++) begin
            step();
            for (int k = 0; k < 4; k++) hi[k] += int'(bus.oTestSig[k]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (hi[k] !== expHi[k]) begin
                errors++; $display("FAIL pwm_ch%0d_high got=%0d want=%0d", k, hi[k], expHi[k]);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [3:0] expSeq [4] = '{4'h0, 4'h8, 4'hC, 4'hE};
        int n;
        waitSync(n);
        pressBtns(1'b1, 1'b0, 12);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b11) begin
            errors++; $display("FAIL lfsr_leds got=%b want=11", {bus.oLed2, bus.oLed1});
        end
        checks++;
        if (bus.oTestSig !== 4'h1) begin
            errors++; $display("FAIL lfsr_seed got=%h want=1", bus.oTestSig);
        end
        for (int i = 0; i < 4; i++) begin
            waitSync(n);
            step();
            checks++;
            if (bus.oTestSig !== expSeq[i]) begin
                errors++; $display("FAIL lfsr_tick%0d got=%h want=%h (n=%0d)", i, bus.oTestSig, expSeq[i], n);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int t0 = -1, t1 = -1;
        logic prev;
        int   expIv [3] = '{512, 256, 2048};
        logic [1:0] expLed [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        pressBtns(1'b1, 1'b1, 12);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b00) begin
            errors++; $display("FAIL both_mode_wrap got=%b want=00", {bus.oLed2, bus.oLed1});
        end
        waitSync(n);
        waitSync(n);
        checks++;
        if (n !== 1024) begin
            errors++; $display("FAIL both_freq1_sync got=%0d want=1024", n);
        end
        prev = bus.oTestSig[0];
        for (int c = 1; c <= 6000; c++) begin
            step();
            if (!prev && bus.oTestSig[0]) begin
                if (t0 < 0) t0 = c; else if (t1 < 0) t1 = c;
            end
            prev = bus.oTestSig[0];
        end
        checks++;
        if (t0 < 0 || t1 - t0 !== 2048) begin
            errors++; $display("FAIL both_freq1_ch0_period got=%0d want=2048", t1 - t0);
        end
        for (int i = 0; i < 3; i++) begin
            pressBtns(1'b0, 1'b1, 12);
            waitSync(n);
            waitSync(n);
            checks++;
            if (n !== expIv[i]) begin
                errors++; $display("FAIL freq_press%0d_sync got=%0d want=%0d", i, n, expIv[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pressBtns(1'b1, 1'b0, 12);
            checks++;
            if ({bus.oLed2, bus.oLed1} !== expLed[i]) begin
                errors++; $display("FAIL mode_press%0d got=%b want=%b", i, {bus.oLed2, bus.oLed1}, expLed[i]);
            end
        end
    endtask

    task automatic test_reset_midpress();
        bus.iBtnMode = 1'b0;
        stepN(6);
        iRstN = 1'b0;
        stepN(2);
        checks++;
        if (bus.oTestSig !== 4'b0000 || bus.oSync !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%b want=0000/0", bus.oTestSig, bus.oSync);
        end
        iRstN = 1'b1;
        stepN(5);
        bus.iBtnMode = 1'b1;
        stepN(20);
        checks++;
        if ({bus.oLed2, bus.oLed1} !== 2'b00) begin
            errors++; $display("FAIL midreset_press_discarded got=%b want=00", {bus.oLed2, bus.oLed1});
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_debounce();
        test_phase();
        test_pwm();
        test_lfsr();
        test_back_to_back();
        test_reset_midpress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/testsiggen.md
TESTSIGGEN -- requirements
Module: testsiggen

Interface
REQ-001 Parameter pChannels, default 4: number of test-signal outputs, legal range 1..8.
REQ-002 Parameter pCntSize, default 16: free-running divider counter width, legal range 12..32.
REQ-003 Parameter pDebounceBits, default 16: debounce counter width; a press must be stable for 2^pDebounceBits cycles.
REQ-004 The design SHALL have one clock; reset is synchronous and active-low.
REQ-005 Port iClk, input, 1 bit: sole clock.
REQ-006 Port iRstN, input, 1 bit: reset, sampled on rising iClk only.
REQ-007 Port iBtnMode, input, 1 bit: mode button, active-low, asynchronous to iClk.
REQ-008 Port iBtnFreq, input, 1 bit: frequency button, active-low, asynchronous to iClk.
REQ-009 Port oLed1, output, 1 bit: mode[0].
REQ-010 Port oLed2, output, 1 bit: mode[1].
REQ-011 Port oTestSig, output, pChannels bits: test signals.
REQ-012 Port oSync, output, 1 bit: one-cycle pulse per tick, used as the scope trigger.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer.
- The debounced state changes only after the synchronized level differs from it for 2^pDebounceBits consecutive cycles.
- Any agreeing sample restarts the count.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced released->pressed transition; release generates no event.
REQ-015 Mode SHALL be a 2-bit register: 0 SQUARE, 1 PHASE, 2 PWM, 3 LFSR.
- Each mode press event increments it; 3 wraps to 0.
REQ-016 freqsel SHALL be a 2-bit register.
- Each freq press event increments it; 3 wraps to 0.
- Tap index tap = pCntSize-1-freqsel.
REQ-017 Simultaneous press events on both buttons SHALL both take effect in the same cycle.
REQ-018 cnt (pCntSize bits) SHALL increment every cycle and wrap to 0.
- cnt is never cleared except by reset.
REQ-019 tick SHALL be asserted when cnt[tap-1:0] is all ones.
- oSync is tick registered once.
REQ-020 SQUARE mode: channel k SHALL be cnt[tap-k].
REQ-021 PHASE mode: a pChannels-bit Johnson register SHALL shift left on tick, inserting the inverted MSB; channel k = johnson[k].
REQ-022 PWM mode: with phase p = cnt[tap:tap-7], channel k SHALL be high while p < (k+1)*floor(256/(pChannels+1)).
- Compare at 9-bit width.
REQ-023 LFSR mode: a 16-bit register SHALL advance on tick: fb = b0^b2^b3^b5; next = {fb, lfsr[15:1]}; channel k = lfsr[k].
REQ-024 On any mode or freqsel change, the Johnson register SHALL clear to 0 and the LFSR SHALL reload seed 0xACE1 in the same cycle; cnt is unaffected.
REQ-025 oTestSig SHALL be registered: one cycle latency from cnt, johnson and lfsr state to output.
REQ-026 The Johnson register and the LFSR SHALL run in every mode, not only the selected one.

Reset
REQ-027 While iRstN is low at a rising iClk, the block SHALL load:
- cnt=0, mode=0, freqsel=0;
- debounced states = released, debounce counters = 0, synchronizers = 1 (released);
- johnson=0, lfsr=0xACE1;
- oTestSig=0, oSync=0, oLed1=0, oLed2=0.
REQ-028 Reset asserted mid-press or mid-debounce SHALL discard the press; no event is generated after release unless the button is re-qualified.

Structure
REQ-029 Package testsig_pkg SHALL hold:
- the mode encoding constants;
- LFSR seed 0xACE1 and tap positions;
- the PWM field width (8).
REQ-030 Sub-module btn_debounce (synchronizer, debouncer, press-event pulse), parametrised by pDebounceBits, SHALL be instantiated once per button.
REQ-031 Parameter legality (pCntSize >= pChannels+11, pChannels <= 8) SHALL be checked at elaboration.

Verification (pChannels=4, pCntSize=12, pDebounceBits=3)
REQ-032 Release reset, no buttons -> oTestSig[0] first rises at the 2049th clock after release, period 4096; oTestSig[1] period 2048; oSync every 2048 cycles.
REQ-033 Mode button low for 5 cycles, then high -> no mode change; low for 12 cycles -> exactly one increment, LEDs show 01.
REQ-034 PHASE mode -> channels step 0000,0001,0011,0111,1111,1110,... one step per 2048 cycles.
REQ-035 PWM mode -> ch0 high 816 of 4096 cycles; ch3 high 3264 of 4096 cycles.
REQ-036 LFSR mode, first tick after mode entry -> lfsr=0x5670, next 0xAB38; oTestSig = lfsr[3:0].
REQ-037 Both buttons qualified in the same cycle -> mode and freqsel both increment; four mode presses return mode to 0.
